// File: rtl/alu_pkg.sv
// ALU opcode set and shared constants used by the ALU and its arbiter.
package alu_pkg;

  localparam int unsigned ALU_OP_LAST   = 8;
  localparam int unsigned REG_WIDTH_DEF = 8;
  localparam int unsigned OP_WIDTH_DEF  = 4;

  typedef enum logic [OP_WIDTH_DEF-1:0] {
    AND = 4'd0,
    SLT = 4'd1,
    OR  = 4'd2,
    ADD = 4'd3,
    SUB = 4'd4,
    SRL = 4'd5,
    SRA = 4'd6,
    BEQ = 4'd7,
    MEM = 4'd8
  } alu_op_e;

  // Ops whose car_out byte carries meaning (overflow or shifted-out bits).
  function automatic logic op_has_carry(input int unsigned op);
    return (op >= 32'(ADD)) && (op <= 32'(SRA));
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU. res_out/car_out/jump are only meaningful for the
// ops that define them; other ops leave unrelated values on those outputs.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned REG_WIDTH = REG_WIDTH_DEF,
  parameter int unsigned OP_WIDTH  = OP_WIDTH_DEF
) (
  input  logic [REG_WIDTH-1:0] ra,
  input  logic [REG_WIDTH-1:0] rb,
  input  logic [OP_WIDTH-1:0]  op,
  output logic [REG_WIDTH-1:0] res_out,
  output logic [REG_WIDTH-1:0] car_out,
  output logic                 zero,
  output logic                 jump
);

  localparam int unsigned SHW = $clog2(REG_WIDTH);

  logic [SHW-1:0]         w_sh;
  logic [REG_WIDTH:0]     w_sum;
  logic [REG_WIDTH:0]     w_dif;
  logic [2*REG_WIDTH-1:0] w_srl;
  logic [2*REG_WIDTH-1:0] w_sra;
  logic                   w_lt;

  // Signed saturation of a sign-extended (REG_WIDTH+1)-bit result.
  function automatic logic [REG_WIDTH-1:0] sat(input logic [REG_WIDTH:0] s);
    if (s[REG_WIDTH] != s[REG_WIDTH-1])
      return s[REG_WIDTH] ? {1'b1, {(REG_WIDTH-1){1'b0}}} : {1'b0, {(REG_WIDTH-1){1'b1}}};
    return s[REG_WIDTH-1:0];
  endfunction

  assign w_sh  = rb[SHW-1:0];
  assign w_sum = {ra[REG_WIDTH-1], ra} + {rb[REG_WIDTH-1], rb};
  assign w_dif = {ra[REG_WIDTH-1], ra} - {rb[REG_WIDTH-1], rb};
  // Shift a double-width word so the bits shifted out land in the low byte.
  assign w_srl = {ra, {REG_WIDTH{1'b0}}} >> w_sh;
  assign w_sra = $signed({ra, {REG_WIDTH{1'b0}}}) >>> w_sh;
  assign w_lt  = $signed(ra) < $signed(rb);

  assign zero = (res_out == '0);
  assign jump = (ra == rb);

  // Opcode decode; defaults leave unrelated values on res_out/car_out.
  always_comb begin
    res_out = ra | rb;
    car_out = ra ^ ~rb;
    case (op)
      OP_WIDTH'(AND): res_out = ra & rb;
      OP_WIDTH'(SLT): res_out = {{(REG_WIDTH-1){1'b0}}, w_lt};
      OP_WIDTH'(OR):  res_out = ra | rb;
      OP_WIDTH'(ADD): begin
        res_out = sat(w_sum);
        car_out = {{(REG_WIDTH-1){1'b0}}, w_sum[REG_WIDTH] != w_sum[REG_WIDTH-1]};
      end
      OP_WIDTH'(SUB): begin
        res_out = sat(w_dif);
        car_out = {{(REG_WIDTH-1){1'b0}}, w_dif[REG_WIDTH] != w_dif[REG_WIDTH-1]};
      end
      OP_WIDTH'(SRL): begin
        res_out = w_srl[2*REG_WIDTH-1:REG_WIDTH];
        car_out = w_srl[REG_WIDTH-1:0];
      end
      OP_WIDTH'(SRA): begin
        res_out = w_sra[2*REG_WIDTH-1:REG_WIDTH];
        car_out = w_sra[REG_WIDTH-1:0];
      end
      OP_WIDTH'(BEQ): res_out = ra - rb;
      OP_WIDTH'(MEM): res_out = ra + rb;
      default:        res_out = ra | rb;
    endcase
  end

endmodule

// File: rtl/alu_rr_arbiter_rr_pick.sv
// Round-robin priority picker: first set request at or above ptr, wrapping.
module rr_pick #(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [ID_WIDTH-1:0] ptr,
  input  logic [NUM_REQ-1:0]  req,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_WIDTH-1:0] idx,
  output logic                any
);

  int unsigned w_j;

  // Scan from ptr upward with wrap; first hit wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    w_j   = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_j = (32'(ptr) + k) % NUM_REQ;
      if (!any && req[w_j]) begin
        grant[w_j] = 1'b1;
        idx        = ID_WIDTH'(w_j);
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Shares one ALU between NUM_REQ requesters with round-robin arbitration
// and a single registered response stage carrying the requester ID.
module alu_rr_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned REG_WIDTH = REG_WIDTH_DEF,
  parameter int unsigned OP_WIDTH  = OP_WIDTH_DEF,
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned ID_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*REG_WIDTH-1:0]  req_ra,
  input  logic [NUM_REQ*REG_WIDTH-1:0]  req_rb,
  input  logic [NUM_REQ*OP_WIDTH-1:0]   req_op,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_WIDTH-1:0]           rsp_id,
  output logic [REG_WIDTH-1:0]          rsp_res,
  output logic [REG_WIDTH-1:0]          rsp_car,
  output logic                          rsp_zero,
  output logic                          rsp_jump,
  output logic                          rsp_err
);

  logic [ID_WIDTH-1:0]  r_ptr;
  logic                 r_rsp_valid;
  logic [ID_WIDTH-1:0]  r_rsp_id;
  logic [REG_WIDTH-1:0] r_rsp_res;
  logic [REG_WIDTH-1:0] r_rsp_car;
  logic                 r_rsp_zero;
  logic                 r_rsp_jump;
  logic                 r_rsp_err;

  logic                 w_stage_free;
  logic                 w_open;
  logic [NUM_REQ-1:0]   w_grant;
  logic [ID_WIDTH-1:0]  w_idx;
  logic                 w_any;
  logic                 w_accept;
  logic [REG_WIDTH-1:0] w_ra;
  logic [REG_WIDTH-1:0] w_rb;
  logic [OP_WIDTH-1:0]  w_op;
  logic [REG_WIDTH-1:0] w_alu_res;
  logic [REG_WIDTH-1:0] w_alu_car;
  logic                 w_alu_zero;
  logic                 w_alu_jump;
  logic                 w_pass_res;
  logic [REG_WIDTH-1:0] w_cln_res;
  logic [REG_WIDTH-1:0] w_cln_car;
  logic                 w_cln_zero;
  logic                 w_cln_jump;
  logic                 w_cln_err;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_WIDTH(ID_WIDTH)
  ) u_pick (
    .ptr  (r_ptr),
    .req  (req_valid),
    .grant(w_grant),
    .idx  (w_idx),
    .any  (w_any)
  );

  assign w_stage_free = !r_rsp_valid || rsp_ready;
  assign w_open       = w_stage_free && !reset;
  assign req_ready    = w_open ? w_grant : '0;
  assign w_accept     = w_open && w_any;

  assign w_ra = req_ra[32'(w_idx)*REG_WIDTH +: REG_WIDTH];
  assign w_rb = req_rb[32'(w_idx)*REG_WIDTH +: REG_WIDTH];
  assign w_op = req_op[32'(w_idx)*OP_WIDTH  +: OP_WIDTH];

  alu #(
    .REG_WIDTH(REG_WIDTH),
    .OP_WIDTH (OP_WIDTH)
  ) u_alu (
    .ra     (w_ra),
    .rb     (w_rb),
    .op     (w_op),
    .res_out(w_alu_res),
    .car_out(w_alu_car),
    .zero   (w_alu_zero),
    .jump   (w_alu_jump)
  );

  // Mask ALU outputs that the current op does not define. The ALU zero flag
  // is reused where res passes through; masked results are zero by definition.
  always_comb begin
    w_cln_err  = (32'(w_op) > ALU_OP_LAST);
    w_pass_res = (32'(w_op) <= 32'(SRA)) || (32'(w_op) == ALU_OP_LAST);
    w_cln_res  = w_pass_res ? w_alu_res : '0;
    w_cln_car  = op_has_carry(32'(w_op)) ? w_alu_car : '0;
    w_cln_jump = (w_op == OP_WIDTH'(BEQ)) ? w_alu_jump : 1'b0;
    w_cln_zero = w_pass_res ? w_alu_zero : 1'b1;
  end

  // Response stage and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_res   <= '0;
      r_rsp_car   <= '0;
      r_rsp_zero  <= 1'b0;
      r_rsp_jump  <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else if (w_accept) begin
      r_ptr       <= (w_idx == ID_WIDTH'(NUM_REQ-1)) ? '0 : w_idx + ID_WIDTH'(1);
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= w_idx;
      r_rsp_res   <= w_cln_res;
      r_rsp_car   <= w_cln_car;
      r_rsp_zero  <= w_cln_zero;
      r_rsp_jump  <= w_cln_jump;
      r_rsp_err   <= w_cln_err;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_res   = r_rsp_res;
  assign rsp_car   = r_rsp_car;
  assign rsp_zero  = r_rsp_zero;
  assign rsp_jump  = r_rsp_jump;
  assign rsp_err   = r_rsp_err;

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Shares one `alu` instance between NUM_REQ requesters, for example the main datapath and the emulator's debug/trace port.
- Arbitration is round-robin. Each requester uses a valid/ready handshake.
- The arbiter issues at most one ALU operation per cycle and registers the result in a single response stage. That stage carries the requester ID and has its own valid/ready handshake.
- The arbiter cleans up ALU outputs that are stale or held over from a previous op before presenting them.

Parameters:
- REG_WIDTH, 8, operand and result width passed to `alu`.
- OP_WIDTH, 4, opcode width passed to `alu`.
- NUM_REQ, 2, number of requesters (2..8).
- ID_WIDTH, $clog2(NUM_REQ), width of the requester ID.

Ports:
- clk  in  1  system clock, all state on the rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  NUM_REQ  request present, one bit per requester.
- req_ready  out  NUM_REQ  grant; the request is accepted at the edge where valid and ready are both 1.
- req_ra  in  NUM_REQ*REG_WIDTH  packed operand A; requester i occupies slice [i*REG_WIDTH +: REG_WIDTH].
- req_rb  in  NUM_REQ*REG_WIDTH  packed operand B, same slicing.
- req_op  in  NUM_REQ*OP_WIDTH  packed opcode; requester i occupies slice [i*OP_WIDTH +: OP_WIDTH].
- rsp_valid  out  1  response stage holds a result.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  ID_WIDTH  index of the requester that issued the op.
- rsp_res  out  REG_WIDTH  ALU result.
- rsp_car  out  REG_WIDTH  carry/shift-out byte.
- rsp_zero  out  1  result equals zero.
- rsp_jump  out  1  branch-taken flag.
- rsp_err  out  1  illegal opcode (9..15).

Behaviour:

Reset:
- All outputs are registered except req_ready.
- On the reset edge: rsp_valid=0; rsp_id, rsp_res, rsp_car=0; rsp_zero=0; rsp_jump=0; rsp_err=0; round-robin pointer=0.
- Reset mid-operation drops the held response. Requests presented in the reset cycle are not accepted (req_ready=0 while reset=1).

Grant (combinational):
- Define stage_free = !rsp_valid || rsp_ready.
- If stage_free, exactly one req_ready bit is set: the first i with req_valid[i]=1, searching from ptr upward with wrap-around. Otherwise req_ready=0.
- req_ready depends combinationally on rsp_ready. This path is accepted.

Round-robin pointer:
- After an accept from requester g, ptr = (g+1) mod NUM_REQ. Otherwise ptr holds.
- At reset ptr=0, so requester 0 has first priority.

Requester rules:
- A requester holds valid and payload stable until accepted; no retraction.
- The arbiter does not check this.

Issue:
- The granted payload is muxed onto the ALU inputs in the same cycle.
- The ALU is combinational. Its outputs are captured at the accept edge.
- Latency: the response appears 1 cycle after accept. Throughput: 1 op/cycle when rsp_ready=1.

Output cleanup (applied before capture):
- rsp_car = ALU car_out for ops 3..6, else 0.
- rsp_jump = ALU jump for op 7, else 0.
- rsp_res = ALU res_out for ops 0..6 and 8, else 0.
- rsp_zero = (captured rsp_res == 0).
- rsp_err = 1 for ops 9..15; for these the response is res 0, car 0, zero 1, jump 0.
- The response is still delivered with rsp_id.

Response stage:
- Captures on accept.
- If rsp_valid=1 and rsp_ready=0, all rsp_* outputs hold and no grant is issued.
- Simultaneous drain and accept in one cycle: the new response replaces the old one with no bubble.
- With no accept and rsp_ready=1, rsp_valid drops to 0.

Decomposition:
- Package `alu_pkg`:
  - enum alu_op_e: AND=0, SLT=1, OR=2, ADD=3, SUB=4, SRL=5, SRA=6, BEQ=7, MEM=8.
  - Constants ALU_OP_LAST=8 and REG_WIDTH_DEF=8.
  - Helper function `op_has_carry(op)`.
- Sub-module `rr_pick`: parameterised round-robin priority picker (NUM_REQ, ptr in, req in → one-hot grant and encoded index out).
- The existing `alu` is instantiated directly.

Test Plan:
- After reset, req0 AND ra=0x05 rb=0x03 → req_ready[0]=1 in the same cycle; next cycle rsp_valid=1, id=0, res=0x01, car=0, zero=0, err=0.
- req1 ADD ra=100 rb=50 → res=127, car=1, id=1; then ADD ra=10 rb=20 → res=30, car=0.
- Both requesters valid every cycle with rsp_ready=1 → grants alternate 0,1,0,1 and rsp_id alternates; 4 responses in 4 consecutive cycles, no bubbles.
- rsp_ready=0 for 3 cycles while holding SRL ra=0x81 rb=1 (res=0x40, car=0x80) → outputs stable and req_ready=0 for all 3 cycles; on release, the next pending request is issued in the same cycle.
- req0 op=12 → rsp_err=1, res=0, zero=1. Then BEQ ra=0x01 rb=0x01 → jump=1, car=0. Then AND → jump=0.
- Assert reset while rsp_valid=1 and both requesters valid → next cycle rsp_valid=0, ptr=0; first grant after reset goes to requester 0.
